// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with per-scan debounce and hex key strobe
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int DWELL_CYCLES        = 100000,
  parameter int DEBOUNCE_SCANS      = 4,
  parameter int REPEAT_DELAY_SCANS  = 125,
  parameter int REPEAT_PERIOD_SCANS = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [3:0] COLS,
  input  logic [3:0] ROWS,
  output logic       KEY_VALID,
  output logic [3:0] KEY_CODE,
  output logic       KEY_HELD
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  if (DWELL_CYCLES < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
      REPEAT_DELAY_SCANS < 1 || REPEAT_PERIOD_SCANS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRESS_PEND, S_HELD, S_RELEASE_PEND} state_t;

  function automatic logic [3:0] legend(input logic [3:0] idx);
    case (idx)
      4'd0:  legend = 4'h1;  4'd1:  legend = 4'h2;  4'd2:  legend = 4'h3;  4'd3:  legend = 4'hA;
      4'd4:  legend = 4'h4;  4'd5:  legend = 4'h5;  4'd6:  legend = 4'h6;  4'd7:  legend = 4'hB;
      4'd8:  legend = 4'h7;  4'd9:  legend = 4'h8;  4'd10: legend = 4'h9;  4'd11: legend = 4'hC;
      4'd12: legend = 4'h0;  4'd13: legend = 4'hF;  4'd14: legend = 4'hE;  default: legend = 4'hD;
    endcase
  endfunction

  logic [3:0]    rows_meta_q, rows_sync_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   buf_q, buf_d;
  logic          last_dwell, end_of_scan;
  logic [4:0]    hit_cnt;
  logic [3:0]    hit_code;
  logic [3:0]    bit_idx;
  logic          scan_empty, scan_key;

  // Buffer holds pressed (active-high) bits at index {row, col}; buf_d already
  // includes the column being latched, so it is the full scan at end of scan.
  always_comb begin
    last_dwell  = (dwell_q == DWELL_LAST);
    end_of_scan = last_dwell && (col_q == 2'd3);
    dwell_d     = last_dwell ? '0 : dwell_q + 1'b1;
    col_d       = last_dwell ? col_q + 2'd1 : col_q;
    buf_d       = buf_q;
    if (last_dwell) begin
      buf_d[{2'd0, col_q}] = ~rows_sync_q[0];
      buf_d[{2'd1, col_q}] = ~rows_sync_q[1];
      buf_d[{2'd2, col_q}] = ~rows_sync_q[2];
      buf_d[{2'd3, col_q}] = ~rows_sync_q[3];
    end
  end

  always_comb begin
    hit_cnt  = '0;
    hit_code = '0;
    bit_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      bit_idx = 4'(i);
      if (buf_d[bit_idx]) begin
        hit_cnt  = hit_cnt + 5'd1;
        hit_code = legend(bit_idx);
      end
    end
    scan_empty = (hit_cnt == 5'd0);
    scan_key   = (hit_cnt == 5'd1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      buf_q       <= '0;
    end else begin
      rows_meta_q <= ROWS;
      rows_sync_q <= rows_meta_q;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      buf_q       <= buf_d;
    end
  end

  assign COLS = ~(4'b0001 << col_q);

  state_t     state_q;
  logic [3:0] cand_q;
  logic [3:0] n_q;
  logic       key_valid_q;
  logic [3:0] key_code_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_SCANS + REPEAT_PERIOD_SCANS + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_inc;
  logic          rep_fired_q, rep_fire;

  // The first repeat waits the long delay; later ones use the short period.
  always_comb begin
    rep_cnt_inc = rep_cnt_q + 1'b1;
    rep_fire    = rep_fired_q ? (rep_cnt_inc == RW'(REPEAT_PERIOD_SCANS))
                              : (rep_cnt_inc == RW'(REPEAT_DELAY_SCANS));
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cand_q      <= 4'h0;
      n_q         <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_fired_q <= 1'b0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      // Multi-key scans fall through untouched: state and counters hold.
      if (end_of_scan && (scan_empty || scan_key)) begin
        case (state_q)
          S_IDLE: begin
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_fired_q <= 1'b0;
`endif
            if (scan_key) begin
              cand_q <= hit_code;
              n_q    <= 4'd1;
              if (DEB == 4'd1) begin
                key_code_q  <= hit_code;
                key_valid_q <= 1'b1;
                state_q     <= S_HELD;
              end else begin
                state_q <= S_PRESS_PEND;
              end
            end
          end
          S_PRESS_PEND: begin
            if (scan_empty) begin
              state_q <= S_IDLE;
            end else if (hit_code != cand_q) begin
              cand_q <= hit_code;
              n_q    <= 4'd1;
            end else if (n_q + 4'd1 == DEB) begin
              key_code_q  <= hit_code;
              key_valid_q <= 1'b1;
              state_q     <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_q   <= '0;
              rep_fired_q <= 1'b0;
`endif
            end else begin
              n_q <= n_q + 4'd1;
            end
          end
          S_HELD: begin
            if (scan_key && hit_code == key_code_q) begin
`ifdef KEYPAD_REPEAT_EN
              if (rep_fire) begin
                key_valid_q <= 1'b1;
                rep_cnt_q   <= '0;
                rep_fired_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_inc;
              end
`endif
            end else begin
              n_q     <= 4'd1;
              state_q <= (DEB == 4'd1) ? S_IDLE : S_RELEASE_PEND;
            end
          end
          default: begin
            if (scan_key && hit_code == key_code_q) begin
              state_q <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
              if (rep_fire) begin
                key_valid_q <= 1'b1;
                rep_cnt_q   <= '0;
                rep_fired_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_inc;
              end
`endif
            end else if (n_q + 4'd1 == DEB) begin
              state_q <= S_IDLE;
            end else begin
              n_q <= n_q + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign KEY_VALID = key_valid_q;
  assign KEY_CODE  = key_code_q;
  assign KEY_HELD  = (state_q == S_HELD) || (state_q == S_RELEASE_PEND);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a scan-level debounce model
module tb_keypad_scanner;
  localparam int DWELL   = 8;
  localparam int DEB     = 3;
  localparam int SCAN    = 4 * DWELL;
  localparam int RDELAY  = 4;
  localparam int RPERIOD = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] COLS, ROWS;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_HELD;

  logic [15:0] pressed = '0;
  int checks = 0, failures = 0;
  int cyc = 0, base = 0, scan_k = 0;

  typedef struct {int cyc; logic [3:0] code;} exp_t;
  exp_t exp_q[$];

  int m_held, m_run, m_rep;
  logic [3:0] m_cand, m_code;

  keypad_scanner #(
    .DWELL_CYCLES(DWELL), .DEBOUNCE_SCANS(DEB),
    .REPEAT_DELAY_SCANS(RDELAY), .REPEAT_PERIOD_SCANS(RPERIOD)
  ) dut (
    .CLK(CLK), .RESET(RESET), .COLS(COLS), .ROWS(ROWS),
    .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE), .KEY_HELD(KEY_HELD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Physical keypad: a pressed key shorts its row to the column being driven low.
  always_comb begin
    ROWS = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!COLS[c])
        for (int r = 0; r < 4; r++)
          if (pressed[r*4+c]) ROWS[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc - base);
    end
  endtask

  function automatic logic [3:0] legend(input int idx);
    logic [3:0] t [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    return t[idx];
  endfunction

  task automatic model_reset();
    m_held = 0; m_run = 0; m_rep = 0; m_cand = 4'h0; m_code = 4'h0;
  endtask

  task automatic push_exp(input logic [3:0] code);
    exp_t e;
    e.cyc  = base + SCAN * scan_k + SCAN;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Debounce as run lengths of identical scan outcomes; multi-key scans are invisible.
  task automatic model_scan(input logic [15:0] p);
    int pc;
    logic [3:0] k;
    pc = $countones(p);
    k = 4'h0;
    if (pc > 1) return;
    for (int i = 0; i < 16; i++) if (p[i]) k = legend(i);
    if (m_held == 0) begin
      if (pc == 0) m_run = 0;
      else if (m_run > 0 && k == m_cand) m_run++;
      else begin m_cand = k; m_run = 1; end
      if (m_run == DEB) begin
        m_held = 1; m_code = k; m_run = 0; m_rep = 0;
        push_exp(k);
      end
    end else if (pc == 1 && k == m_code) begin
      m_run = 0;
`ifdef KEYPAD_REPEAT_EN
      m_rep++;
      if (m_rep >= RDELAY && (m_rep - RDELAY) % RPERIOD == 0) push_exp(k);
`endif
    end else begin
      m_run++;
      if (m_run == DEB) begin m_held = 0; m_run = 0; end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_cols", COLS, 4'b1110);
    check("reset_valid", KEY_VALID, 0);
    check("reset_code", KEY_CODE, 0);
    check("reset_held", KEY_HELD, 0);
    RESET = 1'b0;
    base = cyc;
    scan_k = 0;
    model_reset();
  endtask

  task automatic run_scan(input logic [15:0] p);
    int col;
    pressed = p;
    model_scan(p);
    for (int t = 0; t < SCAN; t++) begin
      col = ((cyc - base) / DWELL) % 4;
      check("cols", COLS, 4'hF ^ (4'h1 << col));
      @(negedge CLK);
    end
    scan_k++;
    check("key_held", KEY_HELD, m_held);
    check("key_code", KEY_CODE, m_code);
  endtask

  // Monitor: every strobe must match the head of the scoreboard in code and cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      check("strobe_missed", 0, 1);
      void'(exp_q.pop_front());
    end
    if (KEY_VALID !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", KEY_CODE, -1);
      end else begin
        check("strobe_cycle", cyc, exp_q[0].cyc);
        check("strobe_code", KEY_CODE, exp_q[0].code);
        void'(exp_q.pop_front());
      end
    end
  end

  localparam logic [15:0] K1 = 16'h0001, K5 = 16'h0020, K9 = 16'h0400;
  localparam logic [15:0] KA = 16'h0008, KD = 16'h8000, K0 = 16'h1000;

  int kind, len, a, b, prev;
  logic [15:0] p;

  initial begin
    do_reset();
    repeat (7) run_scan('0);

    run_scan('0);
    repeat (6) run_scan(K5);
    repeat (4) run_scan('0);

    repeat (3) begin run_scan(KD); run_scan('0); end
    repeat (4) run_scan(KD);
    repeat (4) run_scan('0);

    repeat (4) run_scan(K1 | K9);
    repeat (4) run_scan(K1);
    repeat (4) run_scan('0);

    repeat (2) run_scan(KA);
    pressed = KA;
    repeat (10) @(negedge CLK);
    do_reset();
    repeat (4) run_scan(KA);
    repeat (4) run_scan('0);

    repeat (12) run_scan(K0);
    run_scan('0);
    run_scan(K0);
    repeat (4) run_scan('0);

    prev = 5;
    repeat (30) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      if (kind < 4) p = '0;
      else if (kind < 9) begin
        if ($urandom_range(0, 1) == 1) prev = $urandom_range(0, 15);
        p = 16'h0001 << prev;
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        p = (16'h0001 << a) | (16'h0001 << b);
      end
      repeat (len) run_scan(p);
    end
    repeat (4) run_scan('0);

    check("pending_strobes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 Pmod matrix keypad wired to the board's ROWS/COLS pins and delivers debounced key-press events to the Brainfuck core's input path. It drives one column low at a time, samples the four rows, debounces per full scan, and emits a one-cycle `KEY_VALID` strobe with a 4-bit hex code. It sits between the board pins and `topEntity`'s input consumer, in the `CLK` domain.

## Interface
- `DWELL_CYCLES`, 100000: cycles each column is driven (1 ms at 100 MHz); must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release; range 1..15.
- `REPEAT_DELAY_SCANS`, 125: scans held before the first auto-repeat (used only with `KEYPAD_REPEAT_EN`).
- `REPEAT_PERIOD_SCANS`, 25: scans between subsequent repeats (used only with `KEYPAD_REPEAT_EN`).
- `CLK` input 1: system clock, rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `COLS` output 4: column drive, active low, exactly one bit low at any time.
- `ROWS` input 4: row sense, active low, asynchronous to `CLK`; externally pulled up.
- `KEY_VALID` output 1: one-cycle strobe, new key event.
- `KEY_CODE` output 4: hex legend of the current/last key; stable between strobes.
- `KEY_HELD` output 1: high while a debounced key is held.

## Operation
- `ROWS` passes through a 2-FF synchronizer before use.
- Column index `c` is 0..3; `COLS = ~(4'b0001 << c)`. The dwell counter counts 0..`DWELL_CYCLES`-1. On the last dwell cycle the synchronized rows are latched into the scan buffer for column `c`, then `c` increments, wrapping from 3 to 0.
- End of scan is the last dwell cycle of column 3. The raw result is computed from the 16 buffered bits:
  - none low gives EMPTY.
  - exactly one low gives that key.
  - two or more low gives MULTI, which is ignored: the FSM holds its state and counters unchanged.
- Key map (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D. `KEY_CODE` holds the legend's hex value.
- FSM, evaluated once per end of scan (unit = one scan, debounce counter `n`):
  - IDLE: a key K sets cand=K, n=1, and goes to PRESS_PEND; if `DEBOUNCE_SCANS`=1 the accept happens immediately.
  - PRESS_PEND: the same K increments n. When n reaches `DEBOUNCE_SCANS`: `KEY_CODE`=K, `KEY_VALID` pulses, go to HELD. A different key restarts with cand=new key, n=1. EMPTY returns to IDLE.
  - HELD: the same K stays. EMPTY sets n=1 and goes to RELEASE_PEND. A different key is treated as EMPTY.
  - RELEASE_PEND: EMPTY increments n; when n reaches `DEBOUNCE_SCANS`, go to IDLE. The held key returns to HELD. Any other key is treated as EMPTY.
- `KEY_HELD` = (state is HELD or RELEASE_PEND).
- Reset mid-scan aborts the scan. The scan buffer is cleared, `c`=0, and the FSM goes to IDLE. A key held through reset must be re-debounced from zero before it produces a strobe.

## Timing
- Reset values: `COLS`=4'b1110, `KEY_VALID`=0, `KEY_CODE`=0, `KEY_HELD`=0, `c`=0, dwell=0, FSM=IDLE.
- Scan period is 4×`DWELL_CYCLES` cycles. Rows are sampled on the last dwell cycle, so ≥ `DWELL_CYCLES`-1 cycles of settling cover the synchronizer's 2-cycle latency.
- `KEY_VALID` is registered. It is high on the cycle after the end-of-scan cycle that completes debounce, for exactly 1 cycle.
- `KEY_CODE` and `KEY_HELD` update in that same cycle.
- Press-to-strobe latency is at most (`DEBOUNCE_SCANS`+1) scans + 3 cycles.
- No back-pressure: the consumer must accept a strobe in its cycle.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD, a scan counter starts at acceptance. After `REPEAT_DELAY_SCANS` scans `KEY_VALID` re-pulses with the same code, then again every `REPEAT_PERIOD_SCANS` scans. Scans spent in RELEASE_PEND do not reset the counter if the FSM returns to HELD. The counter clears on IDLE.
- Not defined: one strobe per press only. The repeat counter and its parameters are not synthesized.

## Test plan
Bench uses `DWELL_CYCLES`=8, `DEBOUNCE_SCANS`=3 (scan = 32 cycles).
- Reset, then hold rows high for 200 cycles → `COLS` cycles 1110, 1101, 1011, 0111 with a period of 8; `KEY_VALID` never asserts; `KEY_CODE`=0.
- Model a "5" press (row1 low while col1 low) → exactly one `KEY_VALID` with `KEY_CODE`=4'h5 within 4 scans plus 3 cycles; `KEY_HELD`=1 until 3 empty scans after release.
- "D" bouncing (alternating pressed/released on every other scan for 6 scans), then stable → no strobe during bouncing; one strobe with code 4'hD after 3 stable scans.
- "1" and "9" pressed together → no strobe. Release "9" → one strobe with code 4'h1 after 3 scans.
- Assert `RESET` mid-debounce of "A" (n=2) → outputs return to reset values; the strobe for 4'hA comes 3 full scans after `RESET` deasserts.
- With `KEYPAD_REPEAT_EN`, `REPEAT_DELAY_SCANS`=4, `REPEAT_PERIOD_SCANS`=2, hold "0" → strobes at acceptance, then +4 scans, then every 2 scans, all with code 4'h0.
